// File: rtl/enc64to6_seq.sv
// enc64to6_seq: serves each set bit of a loaded vector as a binary index.
// Define ENC_RR_EN for round-robin selection instead of lowest-index first.
module enc64to6_seq #(
   parameter int N = 64,
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_vec,
   output logic [W-1:0] idx,
   output logic         idx_valid,
   input  logic         idx_ready,
   output logic         busy,
   output logic [W:0]   pend_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t       state, state_nx;
   logic [N-1:0] pend, pend_nx;
   logic [W-1:0] idx_nx;
   logic         vld_nx;
   logic [W:0]   cnt_nx;
   logic [N-1:0] pend_clr;
   logic [N-1:0] one_n;

`ifdef ENC_RR_EN
   logic [W-1:0] ptr, ptr_nx;
`endif

   function automatic logic [W-1:0] first_set(input logic [N-1:0] v);
      logic [W-1:0] k;
      k = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) k = W'(i);
      end
      return k;
   endfunction

   function automatic logic [W:0] popcnt(input logic [N-1:0] v);
      logic [W:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + (W+1)'(v[i]);
      end
      return c;
   endfunction

`ifdef ENC_RR_EN
   // rotate so the start position lands on bit 0, then undo the rotation
   function automatic logic [W-1:0] pick(input logic [N-1:0] v,
                                         input logic [W-1:0] s);
      logic [N-1:0] r;
      r = (v >> s) | (v << (N - int'(s)));
      return W'(first_set(r) + s);
   endfunction
`endif

   assign one_n      = {{(N-1){1'b0}}, 1'b1};
   assign pend_clr   = pend & ~(one_n << idx);
   assign busy       = (state == SERVE);
   assign load_ready = (state == IDLE) & ~flush;

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pend      <= '0;
         idx       <= '0;
         idx_valid <= 1'b0;
         pend_cnt  <= '0;
`ifdef ENC_RR_EN
         ptr       <= '0;
`endif
      end else begin
         state     <= state_nx;
         pend      <= pend_nx;
         idx       <= idx_nx;
         idx_valid <= vld_nx;
         pend_cnt  <= cnt_nx;
`ifdef ENC_RR_EN
         ptr       <= ptr_nx;
`endif
      end
   end

   // next state: load, serve one index per handshake, or flush
   always_comb begin
      state_nx = state;
      pend_nx  = pend;
      idx_nx   = idx;
      vld_nx   = idx_valid;
      cnt_nx   = pend_cnt;
`ifdef ENC_RR_EN
      ptr_nx   = ptr;
`endif
      if (flush) begin
         state_nx = IDLE;
         pend_nx  = '0;
         cnt_nx   = '0;
         vld_nx   = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_valid && (load_vec != '0)) begin
                  state_nx = SERVE;
                  pend_nx  = load_vec;
                  cnt_nx   = popcnt(load_vec);
                  vld_nx   = 1'b1;
`ifdef ENC_RR_EN
                  idx_nx   = pick(load_vec, ptr);
`else
                  idx_nx   = first_set(load_vec);
`endif
               end
            end
            SERVE: begin
               if (idx_ready) begin
                  pend_nx = pend_clr;
                  cnt_nx  = pend_cnt - 1'b1;
`ifdef ENC_RR_EN
                  ptr_nx  = W'(idx + 1'b1);
`endif
                  if (pend_clr == '0) begin
                     state_nx = IDLE;
                     vld_nx   = 1'b0;
                  end else begin
`ifdef ENC_RR_EN
                     idx_nx = pick(pend_clr, W'(idx + 1'b1));
`else
                     idx_nx = first_set(pend_clr);
`endif
                  end
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enc64to6_seq.sv
// tb_enc64to6_seq: directed and randomized checks of enc64to6_seq
// against a set-of-pending-indices reference model.
module tb_enc64to6_seq;

   localparam int N = 64;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         load_valid;
   logic         load_ready;
   logic [N-1:0] load_vec;
   logic [W-1:0] idx;
   logic         idx_valid;
   logic         idx_ready;
   logic         busy;
   logic [W:0]   pend_cnt;

   int ntest = 0;
   int nfail = 0;

   bit [63:0] mpend;
   int        mptr;

   enc64to6_seq #(.N(N), .W(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_vec(load_vec),
      .idx(idx),
      .idx_valid(idx_valid),
      .idx_ready(idx_ready),
      .busy(busy),
      .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   function automatic int pick(bit [63:0] v, int p);
      for (int j = 0; j < 64; j++) begin
         if (v[(p + j) % 64]) return (p + j) % 64;
      end
      return 0;
   endfunction

   // advance one clock and update the reference model from current inputs
   task automatic cycle();
      bit [63:0] nx;
      int k;
      nx = mpend;
      if (flush) nx = '0;
      else if (mpend == 0) begin
         if (load_valid) nx = load_vec;
      end else if (idx_ready) begin
         k = pick(mpend, mptr);
         nx[k] = 1'b0;
`ifdef ENC_RR_EN
         mptr = (k + 1) % 64;
`endif
      end
      @(posedge clk);
      #1;
      mpend = nx;
   endtask

   task automatic do_reset();
      flush = 0; load_valid = 0; load_vec = '0; idx_ready = 0;
      rst_n = 0;
      #2;
      rst_n = 1;
      mpend = '0;
      mptr = 0;
   endtask

   task automatic test_reset();
      flush = 0; load_valid = 0; load_vec = '0; idx_ready = 0;
      rst_n = 0; mpend = '0; mptr = 0;
      #23;
      rst_n = 1;
      @(posedge clk); #1;
      ntest++;
      if (idx_valid !== 1'b0 || pend_cnt !== 7'd0 || load_ready !== 1'b1
          || busy !== 1'b0 || idx !== 6'd0) begin
         nfail++;
         $display("FAIL reset_vals: vld=%b cnt=%0d lr=%b busy=%b idx=%0d want 0 0 1 0 0",
                  idx_valid, pend_cnt, load_ready, busy, idx);
      end
      load_vec = '1; load_valid = 1;
      cycle();
      load_valid = 0;
      ntest++;
      if (idx_valid !== 1'b1 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL reset_load: vld=%b busy=%b want 1 1", idx_valid, busy);
      end
      #2;
      rst_n = 0;
      #1;
      ntest++;
      if (idx_valid !== 1'b0 || pend_cnt !== 7'd0 || load_ready !== 1'b1
          || busy !== 1'b0 || idx !== 6'd0) begin
         nfail++;
         $display("FAIL reset_async: vld=%b cnt=%0d lr=%b busy=%b idx=%0d want 0 0 1 0 0",
                  idx_valid, pend_cnt, load_ready, busy, idx);
      end
      rst_n = 1;
      mpend = '0; mptr = 0;
      load_vec = '0; load_valid = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         ntest++;
         if (idx_valid !== 1'b0 || load_ready !== 1'b1) begin
            nfail++;
            $display("FAIL zero_load: vld=%b lr=%b want 0 1", idx_valid, load_ready);
         end
      end
      load_valid = 0;
   endtask

   task automatic test_full_stream();
      do_reset();
      load_vec = 64'h8000_0000_0000_0001; load_valid = 1; idx_ready = 1;
      cycle();
      load_valid = 0;
      ntest++;
      if (idx_valid !== 1'b1 || idx !== 6'd0 || pend_cnt !== 7'd2) begin
         nfail++;
         $display("FAIL stream_1: vld=%b idx=%0d cnt=%0d want 1 0 2", idx_valid, idx, pend_cnt);
      end
      cycle();
      ntest++;
      if (idx_valid !== 1'b1 || idx !== 6'd63 || pend_cnt !== 7'd1) begin
         nfail++;
         $display("FAIL stream_2: vld=%b idx=%0d cnt=%0d want 1 63 1", idx_valid, idx, pend_cnt);
      end
      cycle();
      ntest++;
      if (idx_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || pend_cnt !== 7'd0) begin
         nfail++;
         $display("FAIL stream_idle: vld=%b busy=%b lr=%b cnt=%0d want 0 0 1 0",
                  idx_valid, busy, load_ready, pend_cnt);
      end
      idx_ready = 0;
   endtask

   task automatic test_backpressure();
      do_reset();
      load_vec = 64'h0000_0000_0000_00F0; load_valid = 1; idx_ready = 0;
      cycle();
      load_valid = 0;
      for (int i = 0; i < 5; i++) begin
         ntest++;
         if (idx_valid !== 1'b1 || idx !== 6'd4 || pend_cnt !== 7'd4) begin
            nfail++;
            $display("FAIL bp_hold: vld=%b idx=%0d cnt=%0d want 1 4 4", idx_valid, idx, pend_cnt);
         end
         cycle();
      end
      idx_ready = 1;
      for (int e = 4; e < 8; e++) begin
         ntest++;
         if (idx_valid !== 1'b1 || idx !== 6'(e) || pend_cnt !== 7'(8 - e)) begin
            nfail++;
            $display("FAIL bp_drain: vld=%b idx=%0d cnt=%0d want 1 %0d %0d",
                     idx_valid, idx, pend_cnt, e, 8 - e);
         end
         cycle();
      end
      ntest++;
      if (idx_valid !== 1'b0 || load_ready !== 1'b1) begin
         nfail++;
         $display("FAIL bp_idle: vld=%b lr=%b want 0 1", idx_valid, load_ready);
      end
      idx_ready = 0;
   endtask

   task automatic test_flush();
      do_reset();
      load_vec = '1; load_valid = 1; idx_ready = 1;
      cycle();
      load_valid = 0;
      for (int e = 0; e < 3; e++) begin
         ntest++;
         if (idx_valid !== 1'b1 || idx !== 6'(e) || pend_cnt !== 7'(64 - e)) begin
            nfail++;
            $display("FAIL flush_consume: vld=%b idx=%0d cnt=%0d want 1 %0d %0d",
                     idx_valid, idx, pend_cnt, e, 64 - e);
         end
         cycle();
      end
      flush = 1; load_valid = 1; load_vec = 64'h5;
      #1;
      ntest++;
      if (load_ready !== 1'b0) begin
         nfail++;
         $display("FAIL flush_lr: lr=%b want 0", load_ready);
      end
      cycle();
      flush = 0;
      #1;
      ntest++;
      if (idx_valid !== 1'b0 || pend_cnt !== 7'd0 || busy !== 1'b0 || load_ready !== 1'b1) begin
         nfail++;
         $display("FAIL flush_idle: vld=%b cnt=%0d busy=%b lr=%b want 0 0 0 1",
                  idx_valid, pend_cnt, busy, load_ready);
      end
      idx_ready = 0;
      cycle();
      load_valid = 0;
      ntest++;
      if (idx_valid !== 1'b1 || idx !== 6'd0 || pend_cnt !== 7'd2) begin
         nfail++;
         $display("FAIL flush_reload: vld=%b idx=%0d cnt=%0d want 1 0 2", idx_valid, idx, pend_cnt);
      end
      flush = 1;
      cycle();
      flush = 0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      load_vec = 64'h2; load_valid = 1; idx_ready = 1;
      cycle();
      load_vec = 64'h4;
      #1;
      ntest++;
      if (idx_valid !== 1'b1 || idx !== 6'd1 || load_ready !== 1'b0) begin
         nfail++;
         $display("FAIL b2b_first: vld=%b idx=%0d lr=%b want 1 1 0", idx_valid, idx, load_ready);
      end
      cycle();
      ntest++;
      if (idx_valid !== 1'b0 || load_ready !== 1'b1) begin
         nfail++;
         $display("FAIL b2b_gap: vld=%b lr=%b want 0 1", idx_valid, load_ready);
      end
      cycle();
      load_valid = 0;
      ntest++;
      if (idx_valid !== 1'b1 || idx !== 6'd2 || pend_cnt !== 7'd1) begin
         nfail++;
         $display("FAIL b2b_second: vld=%b idx=%0d cnt=%0d want 1 2 1", idx_valid, idx, pend_cnt);
      end
      cycle();
      idx_ready = 0;
   endtask

`ifdef ENC_RR_EN
   task automatic test_rr();
      do_reset();
      load_vec = 64'h11; load_valid = 1; idx_ready = 1;
      cycle();
      load_valid = 0;
      ntest++;
      if (idx !== 6'd0) begin
         nfail++;
         $display("FAIL rr_first: idx=%0d want 0", idx);
      end
      cycle();
      idx_ready = 0; flush = 1;
      cycle();
      flush = 0;
      load_valid = 1; idx_ready = 1;
      cycle();
      load_valid = 0;
      ntest++;
      if (idx_valid !== 1'b1 || idx !== 6'd4) begin
         nfail++;
         $display("FAIL rr_reload1: vld=%b idx=%0d want 1 4", idx_valid, idx);
      end
      cycle();
      ntest++;
      if (idx_valid !== 1'b1 || idx !== 6'd0) begin
         nfail++;
         $display("FAIL rr_reload2: vld=%b idx=%0d want 1 0", idx_valid, idx);
      end
      cycle();
      idx_ready = 0;
   endtask
`endif

   task automatic test_random();
      bit [63:0] v;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 3))
            0: v = '0;
            1: begin v = '0; v[$urandom_range(0, 63)] = 1'b1; end
            2: v = {$urandom, $urandom};
            default: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         endcase
         load_vec   = v;
         load_valid = ($urandom_range(0, 1) == 1);
         idx_ready  = ($urandom_range(0, 9) < 7);
         flush      = ($urandom_range(0, 29) == 0);
         #1;
         ntest++;
         if (load_ready !== ((mpend == 0) && !flush)) begin
            nfail++;
            $display("FAIL rnd_lr: lr=%b want %b", load_ready, (mpend == 0) && !flush);
         end
         cycle();
         ntest++;
         if (idx_valid !== (mpend != 0) || busy !== (mpend != 0)
             || pend_cnt !== 7'($countones(mpend))) begin
            nfail++;
            $display("FAIL rnd_state: vld=%b busy=%b cnt=%0d want %b %b %0d",
                     idx_valid, busy, pend_cnt, mpend != 0, mpend != 0, $countones(mpend));
         end
         if (mpend != 0) begin
            ntest++;
            if (idx !== 6'(pick(mpend, mptr))) begin
               nfail++;
               $display("FAIL rnd_idx: idx=%0d want %0d", idx, pick(mpend, mptr));
            end
         end
      end
      flush = 0; load_valid = 0; idx_ready = 0;
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_backpressure();
      test_flush();
      test_back_to_back();
`ifdef ENC_RR_EN
      test_rr();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
